video_timing: RTL and testbench

Raster timing generator that consumes the 5 MHz pixel clock-enable from the clock-enable generator and produces horizontal/vertical counters, sync, blanking and per-line/per-frame strobes. It runs entirely on the 10 MHz `clk` and advances only on `ce5` cycles. It sits between the clock-enable generator and the video/playfield pipeline and the CPU interrupt logic.

---
 rtl/video_pkg.sv | 28 ++
 rtl/video_timing_sync_counter.sv | 63 ++++++
 rtl/video_timing.sv | 95 +++++++++
 tb/tb_video_timing.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster timing constants and types
package video_pkg;

    // Counter width for both hcount and vcount (covers totals up to 512).
    localparam int VC_W = 9;

    // Default raster: 320 x 256 pixel clocks at 5 MHz -> 64 us lines, 61.04 Hz frames.
    localparam int DEF_H_TOTAL      = 320;
    localparam int DEF_H_ACTIVE     = 256;
    localparam int DEF_H_SYNC_START = 272;
    localparam int DEF_H_SYNC_LEN   = 32;
    localparam int DEF_V_TOTAL      = 256;
    localparam int DEF_V_ACTIVE     = 232;
    localparam int DEF_V_SYNC_START = 240;
    localparam int DEF_V_SYNC_LEN   = 3;
    localparam int DEF_IRQ_EVERY    = 64;

    // Raster position and decodes bundled for downstream pipeline stages.
    typedef struct packed {
        logic [VC_W-1:0] hcount;
        logic [VC_W-1:0] vcount;
        logic            hsync_n;
        logic            vsync_n;
        logic            hblank;
        logic            vblank;
    } video_timing_t;

endpackage

// File: rtl/video_timing_sync_counter.sv
// rtl/video_timing_sync_counter.sv - modulo counter with wrap, blank and sync decode
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : advance enable
//   count        : current count, 0..TOTAL-1
//   wrap         : combinational, high when en is set and count is at TOTAL-1
//   blank        : registered, count >= ACTIVE
//   sync_n       : registered, low for SYNC_START <= count < SYNC_START+SYNC_LEN
module sync_counter
    import video_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int ACTIVE     = DEF_H_ACTIVE,
    parameter int SYNC_START = DEF_H_SYNC_START,
    parameter int SYNC_LEN   = DEF_H_SYNC_LEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    output logic [VC_W-1:0] count,
    output logic            wrap,
    output logic            blank,
    output logic            sync_n
);

    if (!(ACTIVE < SYNC_START && SYNC_START + SYNC_LEN <= TOTAL && TOTAL <= 2 ** VC_W)) begin : g_illegal
        $error("sync_counter: illegal timing parameters");
    end

    localparam logic [VC_W-1:0] LAST     = VC_W'(TOTAL - 1);
    localparam logic [VC_W:0]   ACT_END  = (VC_W + 1)'(ACTIVE);
    localparam logic [VC_W:0]   SYNC_BEG = (VC_W + 1)'(SYNC_START);
    localparam logic [VC_W:0]   SYNC_END = (VC_W + 1)'(SYNC_START + SYNC_LEN);

    logic [VC_W-1:0] count_next;
    logic [VC_W:0]   nx;

    always_comb begin
        wrap       = en && (count == LAST);
        count_next = count;
        if (en) begin
            count_next = (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Decode from the next value so the registered decodes line up with count.
    // The extra bit lets SYNC_START+SYNC_LEN reach 512 without overflow.
    assign nx = {1'b0, count_next};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            blank  <= 1'b0;
            sync_n <= 1'b1;
        end else if (en) begin
            count  <= count_next;
            blank  <= (nx >= ACT_END);
            sync_n <= !((nx >= SYNC_BEG) && (nx < SYNC_END));
        end
    end

endmodule

// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster timing generator advancing on the 5 MHz pixel enable
//
// Ports:
//   clk, reset_n      : 10 MHz clock, asynchronous active-low reset
//   ce5               : pixel advance enable, one clk wide
//   hcount, vcount    : raster position
//   hsync_n, vsync_n  : active-low syncs
//   hblank, vblank    : active-high blanking
//   line_start        : one-clk strobe when hcount wraps to 0
//   frame_start       : one-clk strobe when hcount and vcount both wrap to 0
//   irq               : one-clk strobe at the start of lines with vcount % IRQ_EVERY == 0
module video_timing
    import video_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
    parameter int IRQ_EVERY    = DEF_IRQ_EVERY
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce5,
    output logic [VC_W-1:0] hcount,
    output logic [VC_W-1:0] vcount,
    output logic            hsync_n,
    output logic            vsync_n,
    output logic            hblank,
    output logic            vblank,
    output logic            line_start,
    output logic            frame_start,
    output logic            irq
);

    if (IRQ_EVERY < 1 || (IRQ_EVERY & (IRQ_EVERY - 1)) != 0) begin : g_illegal_irq
        $error("video_timing: IRQ_EVERY must be a power of two");
    end

    localparam logic [VC_W-1:0] IRQ_MASK = VC_W'(IRQ_EVERY - 1);

    logic            h_wrap;
    logic            v_wrap;
    logic [VC_W-1:0] v_new;

    sync_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN)
    ) u_h (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ce5),
        .count   (hcount),
        .wrap    (h_wrap),
        .blank   (hblank),
        .sync_n  (hsync_n)
    );

    // Vertical advances only on the horizontal wrap, so vsync/vblank change at hcount 0.
    sync_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN)
    ) u_v (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (h_wrap),
        .count   (vcount),
        .wrap    (v_wrap),
        .blank   (vblank),
        .sync_n  (vsync_n)
    );

    // Line number the raster moves onto when the current line wraps.
    assign v_new = v_wrap ? '0 : vcount + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            irq         <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            irq         <= h_wrap && ((v_new & IRQ_MASK) == '0);
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - directed self-checking bench for video_timing
module tb_video_timing;

    localparam int HT  = 320;
    localparam int HA  = 256;
    localparam int HSS = 272;
    localparam int HSL = 32;
    localparam int VT  = 40;
    localparam int VA  = 32;
    localparam int VSS = 34;
    localparam int VSL = 3;
    localparam int IE  = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce5 = 1'b0;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       hsync_n, vsync_n, hblank, vblank;
    logic       line_start, frame_start, irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int guard;
    int eh = 0;
    int ev = 0;
    logic e_ls = 1'b0, e_fs = 1'b0, e_irq = 1'b0;
    int ls_cyc[$];
    int fs_cyc[$];
    int irq_lines[$];
    int vs_lines[$];

    always #50 clk = ~clk;

    video_timing #(
        .H_TOTAL (HT), .H_ACTIVE (HA), .H_SYNC_START (HSS), .H_SYNC_LEN (HSL),
        .V_TOTAL (VT), .V_ACTIVE (VA), .V_SYNC_START (VSS), .V_SYNC_LEN (VSL),
        .IRQ_EVERY (IE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce5         (ce5),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .hblank      (hblank),
        .vblank      (vblank),
        .line_start  (line_start),
        .frame_start (frame_start),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] obs_vec();
        return {hcount, vcount, hsync_n, vsync_n, hblank, vblank, line_start, frame_start, irq};
    endfunction

    function automatic logic [24:0] exp_vec();
        return {9'(eh), 9'(ev),
                !(eh >= HSS && eh < HSS + HSL), !(ev >= VSS && ev < VSS + VSL),
                (eh >= HA), (ev >= VA), e_ls, e_fs, e_irq};
    endfunction

    localparam logic [24:0] RESET_VEC = {9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // One clk with the given ce5; advances the reference position and compares every output.
    task automatic step(input logic ce);
        ce5 = ce;
        @(posedge clk);
        cyc++;
        if (ce) begin
            e_ls = (eh == HT - 1);
            eh   = e_ls ? 0 : eh + 1;
            if (e_ls) ev = (ev == VT - 1) ? 0 : ev + 1;
            e_fs  = e_ls && (ev == 0);
            e_irq = e_ls && (ev % IE == 0);
        end else begin
            e_ls = 1'b0; e_fs = 1'b0; e_irq = 1'b0;
        end
        #1;
        chk("state", 32'(obs_vec()), 32'(exp_vec()));
        if (line_start) ls_cyc.push_back(cyc);
        if (frame_start) fs_cyc.push_back(cyc);
        if (irq) irq_lines.push_back(int'(vcount));
        if (line_start && !vsync_n) vs_lines.push_back(int'(vcount));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs_vec()), 32'(RESET_VEC));
        reset_n = 1'b1;

        // First line at 1-in-2 ce5 duty
        ls_cyc.delete();
        step(1'b1);
        chk("first_ce_hcount", 32'(hcount), 32'd1);
        chk("first_ce_no_line_start", 32'(line_start), 32'd0);
        for (int i = 2; i <= HT; i++) begin
            step(1'b0);
            step(1'b1);
        end
        step(1'b0);
        chk("line_end_hcount", 32'(hcount), 32'd0);
        chk("line_end_vcount", 32'(vcount), 32'd1);
        chk("line_start_count", 32'(ls_cyc.size()), 32'd1);

        // Rest of the frame with ce5 high: frame_start, irq lines, vsync lines
        fs_cyc.delete(); irq_lines.delete(); vs_lines.delete();
        for (int i = 0; i < (VT - 1) * HT; i++) step(1'b1);
        chk("frame_start_count", 32'(fs_cyc.size()), 32'd1);
        chk("frame_start_now", 32'(frame_start), 32'd1);
        chk("frame_pos", 32'({hcount, vcount}), 32'd0);
        chk("irq_count", 32'(irq_lines.size()), 32'd5);
        if (irq_lines.size() == 5) begin
            chk("irq_line0", 32'(irq_lines[0]), 32'd8);
            chk("irq_line1", 32'(irq_lines[1]), 32'd16);
            chk("irq_line2", 32'(irq_lines[2]), 32'd24);
            chk("irq_line3", 32'(irq_lines[3]), 32'd32);
            chk("irq_line4", 32'(irq_lines[4]), 32'd0);
        end
        chk("vsync_lines", 32'(vs_lines.size()), 32'd3);
        if (vs_lines.size() == 3) begin
            chk("vsync_first", 32'(vs_lines[0]), 32'(VSS));
            chk("vsync_last", 32'(vs_lines[2]), 32'(VSS + VSL - 1));
        end

        // Random ce5 gaps of 0-7 clk for three lines
        ls_cyc.delete();
        for (int i = 0; i < 3 * HT; i++) begin
            repeat ($urandom_range(0, 7)) step(1'b0);
            step(1'b1);
        end
        chk("gap_line_starts", 32'(ls_cyc.size()), 32'd3);
        chk("gap_vcount", 32'(vcount), 32'd3);

        // Run to line 30, hcount 100, then assert reset between clock edges
        guard = 0;
        while (!(eh == 100 && ev == 30) && guard < 20000) begin
            step(1'b1);
            guard++;
        end
        chk("reach_reset_point", 32'({hcount, vcount}), 32'({9'd100, 9'd30}));
        ce5 = 1'b0;
        #10;
        reset_n = 1'b0;
        #1;
        chk("async_reset_state", 32'(obs_vec()), 32'(RESET_VEC));
        eh = 0; ev = 0; e_ls = 1'b0; e_fs = 1'b0; e_irq = 1'b0;
        @(posedge clk);
        #1;
        chk("held_reset_state", 32'(obs_vec()), 32'(RESET_VEC));
        reset_n = 1'b1;
        step(1'b0);

        // ce5 tied high from 0/0: line period 320 clk, frame period VT*320 clk
        ls_cyc.delete(); fs_cyc.delete();
        t0 = cyc;
        step(1'b1);
        chk("restart_hcount", 32'(hcount), 32'd1);
        chk("restart_no_strobe", 32'({line_start, frame_start, irq}), 32'd0);
        for (int i = 1; i < VT * HT; i++) step(1'b1);
        chk("tied_line_starts", 32'(ls_cyc.size()), 32'(VT));
        chk("tied_ls0", 32'((ls_cyc.size() > 0) ? ls_cyc[0] - t0 : -1), 32'(HT));
        chk("tied_ls1", 32'((ls_cyc.size() > 1) ? ls_cyc[1] - t0 : -1), 32'(2 * HT));
        chk("tied_frame_starts", 32'(fs_cyc.size()), 32'd1);
        chk("tied_frame_period", 32'((fs_cyc.size() > 0) ? fs_cyc[0] - t0 : -1), 32'(VT * HT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
